// File: rtl/icmp_rx.sv
// ICMP receive parser: validates type/code/length/checksum and fires a reply trigger.
// Optional statistics counters are enabled by defining ICMP_RX_STATS_EN.
module icmp_rx #(
   parameter logic [15:0] P_MAX_LEN = 16'd1480,
   parameter logic [15:0] P_MIN_LEN = 16'd8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_icmp_data,
   input  logic        i_icmp_valid,
   input  logic        i_icmp_last,
   output logic        o_trig_reply,
   output logic [15:0] o_trig_seq,
   output logic [15:0] o_trig_id
`ifdef ICMP_RX_STATS_EN
   ,
   output logic [15:0] o_rx_ok_cnt,
   output logic [15:0] o_rx_err_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECV    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [31:0] r_sum, w_sum_nxt, w_sum_base;
   logic [7:0]  r_hi, w_hi_nxt;
   logic [7:0]  r_type, w_type_nxt;
   logic [7:0]  r_code, w_code_nxt;
   logic [15:0] r_id, w_id_nxt;
   logic [15:0] r_seq, w_seq_nxt;
   logic [15:0] w_idx, w_len, w_word;
   logic        w_snap, w_len_err;

   logic        r_p0_vld, r_p1_vld, r_p2_vld;
   logic [31:0] r_p0_sum;
   logic [16:0] r_p1_sum, r_p2_sum;
   logic        r_hdr_ok;
   logic [15:0] r_snap_id, r_snap_seq;
   logic        w_accept, w_reject;

   // Next-state, field capture and checksum accumulation per accepted byte
   always_comb begin
      w_state_nxt  = r_state;
      w_rx_cnt_nxt = r_rx_cnt;
      w_sum_nxt    = r_sum;
      w_hi_nxt     = r_hi;
      w_type_nxt   = r_type;
      w_code_nxt   = r_code;
      w_id_nxt     = r_id;
      w_seq_nxt    = r_seq;
      w_snap       = 1'b0;
      w_len_err    = 1'b0;
      // a byte seen in IDLE is always byte 0 of a fresh frame
      w_idx        = (r_state == S_IDLE) ? 16'd0 : r_rx_cnt;
      w_len        = w_idx + 16'd1;
      w_sum_base   = (r_state == S_IDLE) ? 32'd0 : r_sum;
      w_word       = w_idx[0] ? {r_hi, i_icmp_data} : {i_icmp_data, 8'h00};
      case (r_state)
         S_IDLE, S_RECV: begin
            if (i_icmp_valid) begin
               w_rx_cnt_nxt = w_len;
               w_hi_nxt     = i_icmp_data;
               case (w_idx)
                  16'd0:   w_type_nxt      = i_icmp_data;
                  16'd1:   w_code_nxt      = i_icmp_data;
                  16'd4:   w_id_nxt[15:8]  = i_icmp_data;
                  16'd5:   w_id_nxt[7:0]   = i_icmp_data;
                  16'd6:   w_seq_nxt[15:8] = i_icmp_data;
                  16'd7:   w_seq_nxt[7:0]  = i_icmp_data;
                  default: w_hi_nxt        = i_icmp_data;
               endcase
               if (w_idx[0] || i_icmp_last) begin
                  w_sum_nxt = w_sum_base + {16'd0, w_word};
               end else begin
                  w_sum_nxt = w_sum_base;
               end
               if (i_icmp_last) begin
                  w_state_nxt = S_IDLE;
                  if (w_len < P_MIN_LEN) begin
                     w_len_err = 1'b1;
                  end else begin
                     w_snap = 1'b1;
                  end
               end else if (w_len >= P_MAX_LEN) begin
                  w_state_nxt = S_DISCARD;
               end else begin
                  w_state_nxt = S_RECV;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_DISCARD: begin
            if (i_icmp_valid && i_icmp_last) begin
               w_state_nxt = S_IDLE;
               w_len_err   = 1'b1;
            end else begin
               w_state_nxt = S_DISCARD;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Receive state and captured-field registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_rx_cnt <= 16'd0;
         r_sum    <= 32'd0;
         r_hi     <= 8'd0;
         r_type   <= 8'd0;
         r_code   <= 8'd0;
         r_id     <= 16'd0;
         r_seq    <= 16'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_rx_cnt <= w_rx_cnt_nxt;
         r_sum    <= w_sum_nxt;
         r_hi     <= w_hi_nxt;
         r_type   <= w_type_nxt;
         r_code   <= w_code_nxt;
         r_id     <= w_id_nxt;
         r_seq    <= w_seq_nxt;
      end
   end

   // Check pipeline: snapshot, then two end-around-carry folds
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_p0_vld   <= 1'b0;
         r_p1_vld   <= 1'b0;
         r_p2_vld   <= 1'b0;
         r_p0_sum   <= 32'd0;
         r_p1_sum   <= 17'd0;
         r_p2_sum   <= 17'd0;
         r_hdr_ok   <= 1'b0;
         r_snap_id  <= 16'd0;
         r_snap_seq <= 16'd0;
      end else begin
         r_p0_vld <= w_snap;
         if (w_snap) begin
            r_p0_sum   <= w_sum_nxt;
            r_hdr_ok   <= (w_type_nxt == 8'd8) && (w_code_nxt == 8'd0);
            r_snap_id  <= w_id_nxt;
            r_snap_seq <= w_seq_nxt;
         end
         r_p1_vld <= r_p0_vld;
         r_p1_sum <= {1'b0, r_p0_sum[31:16]} + {1'b0, r_p0_sum[15:0]};
         r_p2_vld <= r_p1_vld;
         r_p2_sum <= {16'd0, r_p1_sum[16]} + {1'b0, r_p1_sum[15:0]};
      end
   end

   assign w_accept = r_p2_vld && (r_p2_sum == 17'h0FFFF) && r_hdr_ok;
   assign w_reject = r_p2_vld && !w_accept;

   // Registered trigger pulse and held request identifiers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_trig_reply <= 1'b0;
         o_trig_seq   <= 16'd0;
         o_trig_id    <= 16'd0;
      end else begin
         o_trig_reply <= w_accept;
         if (w_accept) begin
            o_trig_seq <= r_snap_seq;
            o_trig_id  <= r_snap_id;
         end
      end
   end

`ifdef ICMP_RX_STATS_EN
   logic [15:0] r_ok_cnt, r_err_cnt;

   // Frame statistics; a length drop and a pipeline reject may land on the same edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ok_cnt  <= 16'd0;
         r_err_cnt <= 16'd0;
      end else begin
         r_ok_cnt  <= r_ok_cnt + {15'd0, w_accept};
         r_err_cnt <= r_err_cnt + {15'd0, w_len_err} + {15'd0, w_reject};
      end
   end

   assign o_rx_ok_cnt  = r_ok_cnt;
   assign o_rx_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_icmp_rx.sv
// Self-checking bench for icmp_rx: directed frames plus randomized frames against a frame-level model.
module tb_icmp_rx;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [7:0]  i_icmp_data = 8'd0;
   logic        i_icmp_valid = 1'b0;
   logic        i_icmp_last = 1'b0;
   logic        o_trig_reply;
   logic [15:0] o_trig_seq;
   logic [15:0] o_trig_id;
`ifdef ICMP_RX_STATS_EN
   logic [15:0] o_rx_ok_cnt;
   logic [15:0] o_rx_err_cnt;
`endif

   icmp_rx dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_icmp_data  (i_icmp_data),
      .i_icmp_valid (i_icmp_valid),
      .i_icmp_last  (i_icmp_last),
      .o_trig_reply (o_trig_reply),
      .o_trig_seq   (o_trig_seq),
      .o_trig_id    (o_trig_id)
`ifdef ICMP_RX_STATS_EN
      ,
      .o_rx_ok_cnt  (o_rx_ok_cnt),
      .o_rx_err_cnt (o_rx_err_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [15:0] seq;
      logic [15:0] id;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  fr[$];
   logic [15:0] m_seq = 16'd0;
   logic [15:0] m_id  = 16'd0;
   int          m_ok = 0;
   int          m_err = 0;
   int          gap_pct = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One's-complement sum of the frame in fr, big-endian words, odd byte zero-padded
   function automatic logic [15:0] ones_sum();
      int s = 0;
      for (int i = 0; i < fr.size(); i += 2) begin
         s += {fr[i], (i + 1 < fr.size()) ? fr[i+1] : 8'h00};
      end
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return s[15:0];
   endfunction

   function automatic bit model_accept();
      if (fr.size() < 8 || fr.size() > 1480) return 1'b0;
      return (ones_sum() == 16'hFFFF) && (fr[0] == 8'd8) && (fr[1] == 8'd0);
   endfunction

   task automatic fix_csum();
      logic [15:0] s;
      fr[2] = 8'h00;
      fr[3] = 8'h00;
      s = ~ones_sum();
      fr[2] = s[15:8];
      fr[3] = s[7:0];
   endtask

   task automatic mk(input logic [7:0] t, input logic [15:0] cs, input logic [15:0] id,
                     input logic [15:0] sq, input int npay);
      fr.delete();
      fr.push_back(t);      fr.push_back(8'h00);
      fr.push_back(cs[15:8]); fr.push_back(cs[7:0]);
      fr.push_back(id[15:8]); fr.push_back(id[7:0]);
      fr.push_back(sq[15:8]); fr.push_back(sq[7:0]);
      repeat (npay) fr.push_back(8'h00);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_byte(input logic [7:0] d, input logic last);
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
         i_icmp_valid = 1'b0;
         i_icmp_last  = 1'($urandom_range(1));
         i_icmp_data  = 8'($urandom);
         tick();
      end
      i_icmp_valid = 1'b1;
      i_icmp_data  = d;
      i_icmp_last  = last;
      tick();
   endtask

   task automatic send_frame();
      exp_t e;
      for (int i = 0; i < fr.size(); i++) drive_byte(fr[i], i == fr.size() - 1);
      i_icmp_valid = 1'b0;
      i_icmp_last  = 1'b0;
      if (model_accept()) begin
         e.cyc = cyc + 3;
         e.id  = {fr[4], fr[5]};
         e.seq = {fr[6], fr[7]};
         exp_q.push_back(e);
         m_seq = e.seq;
         m_id  = e.id;
         m_ok++;
      end else begin
         m_err++;
      end
   endtask

   task automatic drain_and_check(input string tag);
      repeat (6) tick();
      chk({tag, "_seq"}, o_trig_seq, m_seq);
      chk({tag, "_id"}, o_trig_id, m_id);
`ifdef ICMP_RX_STATS_EN
      chk({tag, "_okcnt"}, o_rx_ok_cnt, m_ok[15:0]);
      chk({tag, "_errcnt"}, o_rx_err_cnt, m_err[15:0]);
`endif
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_icmp_valid = 1'b0;
      i_icmp_last  = 1'b0;
      exp_q.delete();
      m_seq = 16'd0;
      m_id  = 16'd0;
      m_ok  = 0;
      m_err = 0;
      tick();
      chk("rst_reply", o_trig_reply, 1'b0);
      chk("rst_seq", o_trig_seq, 16'd0);
      chk("rst_id", o_trig_id, 16'd0);
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   // Pulse monitor: every pulse must match the oldest expectation in time and content
   initial begin
      exp_t e;
      forever begin
         tick();
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missing_pulse", 1'b0, 1'b1);
            void'(exp_q.pop_front());
         end
         if (!i_rst && o_trig_reply) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_seq", o_trig_seq, e.seq);
               chk("pulse_id", o_trig_id, e.id);
            end
         end
      end
   end

   initial begin
      #1;
      do_reset();

      mk(8'd8, 16'hF7FD, 16'h0001, 16'h0001, 32);
      send_frame();
      drain_and_check("req40");

      mk(8'd8, 16'hF7FC, 16'h0001, 16'h0001, 32);
      send_frame();
      drain_and_check("badcsum");

      mk(8'd8, 16'h4CFD, 16'h0001, 16'h0001, 32);
      fr.push_back(8'hAB);
      gap_pct = 40;
      send_frame();
      gap_pct = 0;
      drain_and_check("odd41");

      mk(8'd0, 16'hFFFD, 16'h0001, 16'h0001, 32);
      send_frame();
      mk(8'd8, 16'h0000, 16'h0000, 16'h0000, 0);
      void'(fr.pop_back());
      void'(fr.pop_back());
      send_frame();
      drain_and_check("type0_short");

      mk(8'd8, 16'hF7FD, 16'h0001, 16'h0001, 32);
      send_frame();
      mk(8'd8, 16'hF7FC, 16'h0001, 16'h0002, 32);
      send_frame();
      drain_and_check("b2b");

      mk(8'd8, 16'h0000, 16'h0011, 16'h0003, 32);
      fix_csum();
      for (int i = 0; i < 20; i++) drive_byte(fr[i], 1'b0);
      do_reset();
      mk(8'd8, 16'h0000, 16'h0022, 16'h0005, 32);
      fix_csum();
      send_frame();
      drain_and_check("after_rst");

      mk(8'd8, 16'h0000, 16'h0033, 16'h0006, 8);
      fix_csum();
      send_frame();
      tick();
      do_reset();
      drain_and_check("rst_pipe");

      mk(8'd8, 16'h0000, 16'h0044, 16'h0007, 1473);
      fix_csum();
      send_frame();
      mk(8'd8, 16'h0000, 16'h0055, 16'h0009, 1472);
      fix_csum();
      send_frame();
      drain_and_check("maxlen");

      for (int f = 0; f < 40; f++) begin
         int len = $urandom_range(60, 1);
         fr.delete();
         for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
         if ($urandom_range(99) < 80) fr[0] = 8'd8;
         if (len > 1 && $urandom_range(99) < 85) fr[1] = 8'd0;
         if (len > 3 && $urandom_range(99) < 75) fix_csum();
         gap_pct = ($urandom_range(1) == 1) ? 30 : 0;
         send_frame();
         if ($urandom_range(3) == 0) drain_and_check("rand");
      end
      gap_pct = 0;
      drain_and_check("final");
      chk("pending_pulses", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
